axis_lcd_frame_sched: RTL and testbench

Write-side frame scheduler between the AXI4-Stream video input and the pixel FIFO feeding the LCD driver. It arms on the LCD frame sync and admits a frame only from a tuser start-of-frame beat. It checks line and frame geometry, drops malformed data until the next start-of-frame, and throttles tready with watermark hysteresis on the FIFO write count. All inputs are in the clk domain; lcd_framesync is already synchronised into clk by the caller.

---
 rtl/axis_lcd_frame_sched.sv | 166 ++++++++++++++++
 tb/tb_axis_lcd_frame_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_lcd_frame_sched.sv
// axis_lcd_frame_sched
//   Write-side frame scheduler between an AXI4-Stream video source and the
//   pixel FIFO that feeds the LCD driver. It arms on the LCD frame sync and
//   admits a frame only from a tuser start-of-frame beat. It tracks the
//   x/y position inside the frame and checks the line and frame geometry.
//   Malformed data is discarded until the next start-of-frame. tready is
//   throttled with watermark hysteresis on the FIFO fill count.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   enable          scheduler enable; only takes effect at frame boundaries
//   lcd_framesync   one-cycle frame-start pulse, already in the clk domain
//   axis_tvalid     stream beat valid
//   axis_tuser      start-of-frame marker
//   axis_tlast      end-of-line marker
//   axis_tready     stream ready
//   fifo_full       FIFO full flag
//   fifo_wr_cnt     FIFO write-side fill count
//   fifo_wr_en      FIFO write enable (tdata is wired straight to FIFO din)
//   frame_done      one-cycle pulse after a complete frame
//   err_line_len    one-cycle pulse on a line-length mismatch
//   err_early_sof   one-cycle pulse on a tuser beat in mid-frame
//   frame_cnt       count of completed frames, wraps at 2^16
module axis_lcd_frame_sched #(
  parameter int H_ACTIVE               = 480,
  parameter int V_ACTIVE               = 272,
  parameter int CNT_W                  = 10,
  parameter int FIFO_ALMOSTFULL_DEPTH  = 768,
  parameter int FIFO_ALMOSTEMPTY_DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             lcd_framesync,
  input  logic             axis_tvalid,
  input  logic             axis_tuser,
  input  logic             axis_tlast,
  output logic             axis_tready,
  input  logic             fifo_full,
  input  logic [CNT_W-1:0] fifo_wr_cnt,
  output logic             fifo_wr_en,
  output logic             frame_done,
  output logic             err_line_len,
  output logic             err_early_sof,
  output logic [15:0]      frame_cnt
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]    X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]    Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(FIFO_ALMOSTFULL_DEPTH);
  localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(FIFO_ALMOSTEMPTY_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM, DROP} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            pause_q, pause_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            done_q, done_d;
  logic            err_len_q, err_len_d;
  logic            err_sof_q, err_sof_d;
  logic            acc;
  logic            wr;

  // Hysteresis: set at or above the high mark, clear at or below the low
  // mark, hold in the band between them.
  always_comb begin
    pause_d = pause_q;
    if (fifo_wr_cnt >= AF_LVL)      pause_d = 1'b1;
    else if (fifo_wr_cnt <= AE_LVL) pause_d = 1'b0;
  end

  assign axis_tready = (state_q != IDLE) & ~fifo_full & ~pause_q;
  assign acc         = axis_tvalid & axis_tready;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    wr          = 1'b0;
    done_d      = 1'b0;
    err_len_d   = 1'b0;
    err_sof_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && lcd_framesync) state_d = WAIT_SOF;
      end
      WAIT_SOF, DROP: begin
        if (acc && axis_tuser) begin
          wr      = 1'b1;
          x_d     = XW'(1);
          y_d     = '0;
          state_d = STREAM;
        end else if (state_q == WAIT_SOF && !enable) begin
          // A disarmed scheduler waiting for SOF falls back to IDLE; DROP
          // belongs to a frame in progress, so enable is ignored there.
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (acc) begin
          if (axis_tuser) begin
            // Restart the frame on this beat.
            err_sof_d = 1'b1;
            wr        = 1'b1;
            x_d       = XW'(1);
            y_d       = '0;
          end else if (axis_tlast != (x_q == X_LAST)) begin
            err_len_d = 1'b1;
            state_d   = DROP;
          end else if (axis_tlast && y_q == Y_LAST) begin
            wr          = 1'b1;
            x_d         = '0;
            y_d         = '0;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = enable ? WAIT_SOF : IDLE;
          end else if (axis_tlast) begin
            wr  = 1'b1;
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            wr  = 1'b1;
            x_d = x_q + XW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      pause_q     <= 1'b0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pause_q     <= pause_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
      err_sof_q   <= err_sof_d;
    end
  end

  // wr is only ever raised on an accepted beat, and acceptance already
  // requires fifo_full = 0.
  assign fifo_wr_en    = wr;
  assign frame_done    = done_q;
  assign err_line_len  = err_len_q;
  assign err_early_sof = err_sof_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_lcd_frame_sched.sv
module tb_axis_lcd_frame_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       lcd_framesync = 1'b0;
  logic       axis_tvalid = 1'b0;
  logic       axis_tuser = 1'b0;
  logic       axis_tlast = 1'b0;
  logic       axis_tready;
  logic       fifo_full = 1'b0;
  logic [9:0] fifo_wr_cnt = '0;
  logic       fifo_wr_en;
  logic       frame_done;
  logic       err_line_len;
  logic       err_early_sof;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  axis_lcd_frame_sched #(
    .H_ACTIVE(4), .V_ACTIVE(2), .CNT_W(10),
    .FIFO_ALMOSTFULL_DEPTH(12), .FIFO_ALMOSTEMPTY_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .lcd_framesync(lcd_framesync),
    .axis_tvalid(axis_tvalid), .axis_tuser(axis_tuser), .axis_tlast(axis_tlast),
    .axis_tready(axis_tready), .fifo_full(fifo_full), .fifo_wr_cnt(fifo_wr_cnt),
    .fifo_wr_en(fifo_wr_en), .frame_done(frame_done), .err_line_len(err_line_len),
    .err_early_sof(err_early_sof), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat at the falling edge, check the write strobe before the
  // rising edge, then check the registered pulses it produced.
  task automatic beat(input logic v, input logic u, input logic l,
                      input logic e_wr, input logic e_done,
                      input logic e_len, input logic e_sof);
    @(negedge clk);
    axis_tvalid = v;
    axis_tuser  = u;
    axis_tlast  = l;
    #1;
    chk("wr_en", fifo_wr_en, e_wr);
    @(posedge clk);
    #1;
    chk("frame_done", frame_done, e_done);
    chk("err_line_len", err_line_len, e_len);
    chk("err_early_sof", err_early_sof, e_sof);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    axis_tvalid = 1'b0;
    axis_tuser  = 1'b0;
    axis_tlast  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic framesync_pulse();
    @(negedge clk);
    lcd_framesync = 1'b1;
    @(negedge clk);
    lcd_framesync = 1'b0;
    #1;
  endtask

  // A well-formed 4x2 frame: SOF on beat 0, tlast on beats 3 and 7.
  task automatic good_frame();
    beat(1, 1, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 1, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 1, 1, 1, 0, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", axis_tready, 1'b0);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    idle_cycle();
    chk("idle_no_ready", axis_tready, 1'b0);

    // Plan 1: arm and stream one frame
    framesync_pulse();
    chk("armed_ready", axis_tready, 1'b1);
    good_frame();
    idle_cycle();
    chk("done_one_cycle", frame_done, 1'b0);
    chk("frame_cnt_1", frame_cnt, 16'd1);
    chk("wait_sof_ready", axis_tready, 1'b1);

    // Plan 2: non-SOF beats before the frame are swallowed
    beat(1, 0, 0, 0, 0, 0, 0);
    beat(1, 0, 1, 0, 0, 0, 0);
    beat(1, 0, 0, 0, 0, 0, 0);
    good_frame();
    chk("frame_cnt_2", frame_cnt, 16'd2);

    // Plan 3: short line -> error, drop until SOF, then recover
    beat(1, 1, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 1, 0, 0, 1, 0);
    beat(1, 0, 0, 0, 0, 0, 0);
    chk("drop_ready", axis_tready, 1'b1);
    beat(1, 0, 1, 0, 0, 0, 0);
    good_frame();
    chk("frame_cnt_3", frame_cnt, 16'd3);
    // Long line: no tlast at x = 3
    beat(1, 1, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 0, 0, 1, 0);

    // Plan 4: SOF on beat 5 restarts the frame
    beat(1, 1, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 1, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 1, 0, 1, 0, 0, 1);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 1, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 1, 1, 1, 0, 0);
    chk("frame_cnt_4", frame_cnt, 16'd4);

    // Plan 5: watermark hysteresis and fifo_full
    @(negedge clk);
    axis_tvalid = 1'b0;
    fifo_wr_cnt = 10'd12;
    #1;
    chk("pause_not_yet", axis_tready, 1'b1);
    @(posedge clk); #1;
    chk("pause_set", axis_tready, 1'b0);
    @(negedge clk);
    fifo_wr_cnt = 10'd8;
    @(posedge clk); #1;
    chk("pause_hold", axis_tready, 1'b0);
    @(negedge clk);
    fifo_wr_cnt = 10'd5;
    @(posedge clk); #1;
    chk("pause_hold_5", axis_tready, 1'b0);
    @(negedge clk);
    fifo_wr_cnt = 10'd4;
    @(posedge clk); #1;
    chk("pause_clear", axis_tready, 1'b1);
    @(negedge clk);
    fifo_full = 1'b1;
    axis_tvalid = 1'b1;
    axis_tuser = 1'b1;
    #1;
    chk("full_tready", axis_tready, 1'b0);
    chk("full_no_wr", fifo_wr_en, 1'b0);
    @(negedge clk);
    axis_tvalid = 1'b0;
    axis_tuser = 1'b0;
    fifo_wr_cnt = 10'd12;
    @(posedge clk); #1;
    chk("full_and_pause", axis_tready, 1'b0);
    @(negedge clk);
    fifo_full = 1'b0;
    #1;
    chk("pause_only", axis_tready, 1'b0);
    @(negedge clk);
    fifo_wr_cnt = 10'd0;
    @(posedge clk); #1;
    chk("resume", axis_tready, 1'b1);

    // enable low in WAIT_SOF returns to IDLE; framesync needs enable
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("disable_idle", axis_tready, 1'b0);
    framesync_pulse();
    chk("sync_no_enable", axis_tready, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    framesync_pulse();
    chk("rearm", axis_tready, 1'b1);

    // enable dropped mid-frame completes the frame, then goes IDLE
    beat(1, 1, 0, 1, 0, 0, 0);
    enable = 1'b0;
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 1, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 1, 1, 1, 0, 0);
    chk("frame_cnt_5", frame_cnt, 16'd5);
    chk("end_idle", axis_tready, 1'b0);

    // Plan 6: reset mid-frame at x = 2, y = 1
    @(negedge clk);
    enable = 1'b1;
    framesync_pulse();
    beat(1, 1, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 1, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    axis_tvalid = 1'b1;
    axis_tlast = 1'b1;
    @(posedge clk); #1;
    chk("mrst_tready", axis_tready, 1'b0);
    chk("mrst_wr_en", fifo_wr_en, 1'b0);
    chk("mrst_done", frame_done, 1'b0);
    chk("mrst_err_len", err_line_len, 1'b0);
    chk("mrst_err_sof", err_early_sof, 1'b0);
    chk("mrst_frame_cnt", frame_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    axis_tvalid = 1'b0;
    axis_tlast = 1'b0;
    idle_cycle();
    idle_cycle();
    chk("mrst_needs_sync", axis_tready, 1'b0);
    framesync_pulse();
    good_frame();
    chk("post_rst_cnt", frame_cnt, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
